// File: rtl/ising_energy_eval_pkg.sv
// Shared constants and types for the oscillator Ising machine datapath.
package ising_pkg;

  localparam int unsigned Q_FRAC_BITS = 16;

  // Q16.16 constants shared with the phase-dynamics solver
  localparam logic signed [31:0] ONE     = 32'sh0001_0000;
  localparam logic signed [31:0] PI      = 32'sh0003_243F;
  localparam logic signed [31:0] HALF_PI = 32'sh0001_921F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPIN,
    ST_ACCUM,
    ST_FINISH,
    ST_HOLD
  } state_e;

endpackage

// File: rtl/ising_energy_eval_if.sv
// Phase-vector input handshake, result handshake and best-result readout.
interface ising_energy_eval_if #(
  parameter int unsigned N          = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ACC_WIDTH  = DATA_WIDTH + 2 * $clog2(N)
);

  logic                                  in_valid;
  logic                                  in_ready;
  logic [N-1:0][DATA_WIDTH-1:0]          phi_in;
  logic [N-1:0][N-1:0][DATA_WIDTH-1:0]   J;
  logic                                  clear_best;
  logic                                  out_valid;
  logic                                  out_ready;
  logic signed [ACC_WIDTH-1:0]           energy;
  logic [N-1:0]                          spins;
  logic                                  best_valid;
  logic signed [ACC_WIDTH-1:0]           best_energy;
  logic [N-1:0]                          best_spins;

  // Host / phase solver side
  modport master (
    output in_valid, phi_in, J, clear_best, out_ready,
    input  in_ready, out_valid, energy, spins, best_valid, best_energy, best_spins
  );

  // Energy evaluator side
  modport slave (
    input  in_valid, phi_in, J, clear_best, out_ready,
    output in_ready, out_valid, energy, spins, best_valid, best_energy, best_spins
  );

endinterface

// File: rtl/ising_energy_eval_spin_quantize.sv
// Maps each phase to a binary spin: +1 (bit set) inside [-HALF_PI, HALF_PI].
module ising_spin_quantize
  import ising_pkg::*;
#(
  parameter int unsigned N          = 16,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [N-1:0][DATA_WIDTH-1:0] phi,
  output logic [N-1:0]                 spins_c
);

  localparam logic signed [DATA_WIDTH-1:0] HP = DATA_WIDTH'(HALF_PI);

  // Inclusive window compare; the most negative code falls outside it
  always_comb begin
    spins_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      spins_c[i] = ($signed(phi[i]) >= -HP) && ($signed(phi[i]) <= HP);
    end
  end

endmodule

// File: rtl/ising_energy_eval.sv
// Quantizes a phase vector to spins, accumulates the Ising energy one
// coupling per cycle and tracks the lowest-energy configuration seen.
module ising_energy_eval
  import ising_pkg::*;
#(
  parameter int unsigned N          = 16,
  parameter int unsigned FRAC_BITS  = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ACC_WIDTH  = DATA_WIDTH + 2 * $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  ising_energy_eval_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(N);

  // Constants are fixed Q16.16; reject other formats at elaboration
  if (FRAC_BITS != Q_FRAC_BITS) begin : g_frac_chk
    $error("ising_energy_eval: FRAC_BITS must match Q16.16 constants");
  end
  if (N < 2) begin : g_n_chk
    $error("ising_energy_eval: N must be at least 2");
  end

  state_e                        state_q, state_d;
  logic                          accept_c;
  logic                          last_pair_c;
  logic                          row_end_c;
  logic                          same_c;
  logic signed [ACC_WIDTH-1:0]   j_ext_c;
  logic                          best_load_c;

  logic [IDX_W-1:0]              i_q, j_q;
  logic signed [ACC_WIDTH-1:0]   acc_q;
  logic [N-1:0][DATA_WIDTH-1:0]  phi_q;
  logic [N-1:0]                  spins_c;
  logic [N-1:0]                  spin_vec_q;

  logic                          in_ready_q;
  logic                          out_valid_q;
  logic signed [ACC_WIDTH-1:0]   energy_q;
  logic [N-1:0]                  spins_q;
  logic                          best_valid_q;
  logic signed [ACC_WIDTH-1:0]   best_energy_q;
  logic [N-1:0]                  best_spins_q;

  ising_spin_quantize #(
    .N          (N),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_quant (
    .phi     (phi_q),
    .spins_c (spins_c)
  );

  assign row_end_c   = (j_q == IDX_W'(N - 1));
  assign last_pair_c = (i_q == IDX_W'(N - 2)) && row_end_c;
  assign same_c      = (spin_vec_q[i_q] == spin_vec_q[j_q]);
  assign j_ext_c     = ACC_WIDTH'($signed(bus.J[i_q][j_q]));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and control strobes
  always_comb begin
    state_d     = state_q;
    accept_c    = 1'b0;
    best_load_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          accept_c = 1'b1;
          state_d  = ST_SPIN;
        end
      end
      ST_SPIN:  state_d = ST_ACCUM;
      ST_ACCUM: begin
        if (last_pair_c) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        state_d     = ST_HOLD;
        best_load_c = !best_valid_q || bus.clear_best || (acc_q < best_energy_q);
      end
      ST_HOLD: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Phase latch, spin capture, pair indices and energy accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phi_q      <= '0;
      spin_vec_q <= '0;
      i_q        <= '0;
      j_q        <= '0;
      acc_q      <= '0;
    end else begin
      if (accept_c) phi_q <= bus.phi_in;
      if (state_q == ST_SPIN) begin
        spin_vec_q <= spins_c;
        i_q        <= '0;
        j_q        <= IDX_W'(1);
        acc_q      <= '0;
      end
      if (state_q == ST_ACCUM) begin
        acc_q <= same_c ? (acc_q - j_ext_c) : (acc_q + j_ext_c);
        if (row_end_c) begin
          i_q <= i_q + IDX_W'(1);
          j_q <= i_q + IDX_W'(2);
        end else begin
          j_q <= j_q + IDX_W'(1);
        end
      end
    end
  end

  // Handshake flags and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      energy_q    <= '0;
      spins_q     <= '0;
    end else begin
      in_ready_q  <= (state_d == ST_IDLE);
      out_valid_q <= (state_d == ST_HOLD);
      if (state_q == ST_FINISH) begin
        energy_q <= acc_q;
        spins_q  <= spin_vec_q;
      end
    end
  end

  // Best-result tracking; a load in FINISH overrides a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_valid_q  <= 1'b0;
      best_energy_q <= '0;
      best_spins_q  <= '0;
    end else if (best_load_c) begin
      best_valid_q  <= 1'b1;
      best_energy_q <= acc_q;
      best_spins_q  <= spin_vec_q;
    end else if (bus.clear_best) begin
      best_valid_q  <= 1'b0;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.energy      = energy_q;
  assign bus.spins       = spins_q;
  assign bus.best_valid  = best_valid_q;
  assign bus.best_energy = best_energy_q;
  assign bus.best_spins  = best_spins_q;

endmodule

// File: doc/ising_energy_eval.md
# ising_energy_eval

Downstream stage of the oscillator Ising machine. It accepts a final phase vector from the phase-dynamics solver, quantizes each phase to a binary spin, and computes the Ising energy E = −Σ_{i<j} J_ij·s_i·s_j using one accumulate per clock. It also keeps the best (lowest-energy) spin configuration seen across successive runs, so the host can anneal repeatedly and read back the best solution.

## Interface
- `N`, 16: number of oscillators/spins.
- `FRAC_BITS`, 16: fractional bits of Q16.16 data.
- `DATA_WIDTH`, 32: width of phases and couplings.
- `ACC_WIDTH`, DATA_WIDTH+2·$clog2(N): energy accumulator width (40 at defaults).
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  phase vector on `phi_in` is valid.
- `in_ready`  out  1  block can accept a vector.
- `phi_in`  in  [N-1:0][DATA_WIDTH] signed  Q16.16 phases in [−π, π].
- `J`  in  [N-1:0][N-1:0][DATA_WIDTH] signed  coupling matrix. Must be held stable from accept until `out_valid`.
- `clear_best`  in  1  single-cycle pulse that invalidates the best-result registers.
- `out_valid`  out  1  `energy` and `spins` are valid.
- `out_ready`  in  1  consumer accepts the result.
- `energy`  out  ACC_WIDTH signed  Q(ACC_WIDTH−16).16 energy of the last run.
- `spins`  out  N  bit i = 1 means s_i = +1; bit i = 0 means s_i = −1.
- `best_valid`  out  1  best registers hold a result.
- `best_energy`  out  ACC_WIDTH signed  lowest energy since reset or clear.
- `best_spins`  out  N  spin vector that achieved `best_energy`.

## Operation
- States:
  - IDLE: `in_ready` = 1.
  - SPIN: phases are latched and spins are computed.
  - ACCUM: one (i,j) pair per cycle.
  - FINISH: the result is registered.
  - HOLD: `out_valid` = 1 until `out_ready`.
- Transitions:
  - IDLE → SPIN on `in_valid` && `in_ready`.
  - SPIN → ACCUM unconditionally. Indices are set to (i,j) = (0,1) and the accumulator to 0.
  - ACCUM → FINISH after pair (N−2, N−1).
  - FINISH → HOLD.
  - HOLD → IDLE on `out_ready`.
- Spin rule: s_i = +1 iff −HALF_PI ≤ phi_i ≤ HALF_PI (inclusive), else −1. No abs() is used, so 0x80000000 yields −1.
- Pair order is row-major over the upper triangle: j increments; on j = N−1, i increments and j = i+1.
  - Only J[i][j] with i<j is used. The diagonal and lower triangle are ignored.
- Accumulation: acc ← acc − J[i][j] when s_i = s_j, else acc ← acc + J[i][j]. J is sign-extended to ACC_WIDTH. No multiplier is used and no saturation is applied; ACC_WIDTH guarantees no overflow.
- In FINISH:
  - `energy` ← acc and `spins` ← quantized vector.
  - Best update: if !`best_valid` or acc < `best_energy` (strict), load the best registers and set `best_valid`. On ties the older result is kept.
- `clear_best`:
  - Clears `best_valid` on the next edge in any state.
  - If asserted in FINISH, the clear applies first and the new result is then loaded as best. After that edge, `best_valid` = 1 with the new values.
- `in_valid` outside IDLE is ignored; no input is queued.

## Timing
- Reset values: `in_ready` = 1, `out_valid` = 0, `energy` = 0, `spins` = 0, `best_valid` = 0, `best_energy` = 0, `best_spins` = 0. State = IDLE, indices and accumulator = 0.
- P = N(N−1)/2 pairs.
- Latency: with the accept edge as edge 0, `out_valid` rises after edge P+2. That is 122 cycles at N = 16 and 8 cycles at N = 4.
- `in_ready` falls after the accept edge and rises the cycle after the `out_ready` handshake edge.
- `energy` and `spins` are stable while `out_valid` = 1. They persist after the handshake until the next FINISH.
- Reset asserted mid-run (any state) aborts the run. All outputs take reset values asynchronously, and `in_ready` = 1 once reset deasserts.
- Throughput: one vector per P+4 cycles at best, when `out_ready` is tied high.

## Structure
- Shared package `ising_pkg` holds:
  - Q16.16 constants ONE (0x00010000), PI (0x0003243F) and HALF_PI (0x0001921F), shared with the phase solver.
  - The state typedef for this block.
- Sub-module `ising_spin_quantize` (combinational, N-wide) implements the spin rule. It is reused by any later readout path.
- Index counters, accumulator, FSM and best-tracking registers live in the top module.

## Test plan
- N = 4, all upper J = ONE, phi = {0,0,0,0}, accept → `out_valid` 8 cycles after accept. Expect `spins` = 4'b1111, `energy` = −6.0 (sign-extended 0x…FA0000).
- N = 4, J = ONE, phi = {0, PI, 0, PI} → `spins` = 4'b0101, `energy` = +2.0 (0x20000).
- Quantizer boundaries, phi = {HALF_PI, HALF_PI+1, −HALF_PI, 0x80000000} → `spins` = 4'b0101 (bit 0 first).
- Best tracking:
  - Run test 1, then test 2 → `best_energy` = −6.0, `best_spins` = 4'b1111.
  - Pulse `clear_best`, then rerun test 2 → `best_energy` = +2.0.
  - `clear_best` in the FINISH cycle → `best_valid` = 1 with the new result.
- Backpressure and reset:
  - Hold `out_ready` = 0 for 10 cycles while driving `in_valid` → `energy` and `spins` are stable, `in_ready` = 0, and no new run starts.
  - Assert `rst` during ACCUM → all outputs reach reset values asynchronously, and `in_ready` = 1 after release.
